ldst_pointer_unit: RTL and testbench
====================================

// Module: ldst_pointer_unit
// PURPOSE
//  Sequences AVR LD/ST through pointer pairs X/Y/Z (r26/r28/r30) for the risc8 core.
//  Reads the pointer word and store byte from the regfile, forms the effective address
//  (plain, post-inc, pre-dec, displacement), and runs a req/ack data-memory transaction.
//  Serializes the pointer update (word write) and load data (byte write) onto the
//  regfile's single write port. Sits between the decoder and the regfile/data memory.
// PARAMETERS
//  ADDR_W   16   data-memory address width; mem_addr = eff_addr[ADDR_W-1:0]
//  TIMEOUT  255  ack watchdog limit in cycles; used only with LDST_TIMEOUT_EN
// PORTS
//  clk            in   1       core clock; all state on posedge
//  reset_n        in   1       asynchronous, active-low reset
//  start          in   1       op request; accepted only while busy==0
//  is_store       in   1       1=ST, 0=LD
//  mode           in   2       00 plain, 01 post-inc, 10 pre-dec, 11 displacement (q)
//  q              in   6       displacement, zero-extended
//  ptr_reg        in   6       pointer low register (26/28/30); bit0 must be 0
//  data_reg       in   6       LD destination / ST source register
//  busy           out  1       high from accept cycle+1 until done cycle inclusive
//  done           out  1       one-cycle pulse in final cycle of op
//  rf_a           out  6       regfile word-read address (pointer)
//  rf_b           out  6       regfile byte-read address (store data)
//  rf_Ra          in   16      pointer word; valid 1 cycle after rf_a
//  rf_Rb          in   8       store byte; valid 1 cycle after rf_b
//  rf_write       out  1       regfile write strobe
//  rf_write_word  out  1       1 = 16-bit write to rf_d/rf_d|1
//  rf_d           out  6       regfile write address
//  rf_Rd          out  16      regfile write data (byte writes use [7:0], [15:8]=0)
//  mem_req        out  1       memory request, held until mem_ack
//  mem_we         out  1       1 = write; valid while mem_req
//  mem_addr       out  ADDR_W  effective address; stable while mem_req
//  mem_wdata      out  8       store byte; stable while mem_req
//  mem_ack        in   1       completes transaction in any cycle mem_req is high
//  mem_rdata      in   8       load byte; valid with mem_ack
// BEHAVIOUR
//  Reset: state IDLE; busy, done, rf_write, rf_write_word, mem_req, mem_we = 0;
//   all address/data outputs 0. Reset mid-op aborts; no regfile write is issued.
//  FSM: IDLE -> RD -> REQ -> [PTR] -> [DATA] -> IDLE.
//   IDLE: start latches is_store/mode/q/ptr_reg/data_reg; rf_a=ptr_reg, rf_b=data_reg.
//   RD:   regfile read cycle; rf_a/rf_b held. Next REQ.
//   REQ:  capture rf_Ra/rf_Rb on entry; mem_req=1 until mem_ack (min 1 cycle).
//   PTR:  mode 01/10 only: rf_write=1, rf_write_word=1, rf_d=ptr_reg, rf_Rd=new_ptr.
//   DATA: LD only: rf_write=1, rf_write_word=0, rf_d=data_reg, rf_Rd={8'h0,rdata}.
//  Pointer write precedes data write: if data_reg aliases the pointer, loaded byte wins.
//  Arithmetic (16-bit, modulo 2^16): eff = ptr (00,01), ptr-1 (10), ptr+q (11);
//   new_ptr = ptr+1 (01), ptr-1 (10). 16'hFFFF post-inc -> 16'h0000; 0 pre-dec -> FFFF.
//  done pulses in the cycle of the last required action: REQ-ack cycle (ST or LD
//   mode 00/11 with no writes pending — ST), PTR cycle (ST with update), DATA cycle (LD).
//  Latency with same-cycle ack: ST plain 3 cycles, LD plain 4, LD post-inc 5 (incl. accept).
//  start while busy is ignored. rdata captured on ack; mem_rdata ignored otherwise.
// CONFIGURATION
//  LDST_TIMEOUT_EN defined: counter in REQ; at TIMEOUT cycles without ack, drop mem_req,
//   skip PTR/DATA, pulse done and err (extra 1-bit output err, reset 0, 1-cycle pulse).
//  Undefined: no counter, no err port; REQ waits for mem_ack indefinitely.
// TESTING
//  LD r5, X (X=0x0120, rdata=0xA5, ack in 1st REQ cycle) -> mem_addr 0x0120, r5 write 0xA5, done cycle 4.
//  ST Y+, r7 (Y=0xFFFF, r7=0x3C) -> mem_we=1 addr 0xFFFF wdata 0x3C; word write r28=0x0000.
//  LD r0, -Z (Z=0x0000) -> addr 0xFFFF; r30 word write 0xFFFF then r0 byte write, in that order.
//  LDD r1, Z+63 (Z=0x1000), ack delayed 5 cycles -> mem_addr 0x103F held stable, no pointer write.
//  reset_n low in REQ; start pulsed while busy -> outputs 0, no rf_write; second start ignored.
//  LDST_TIMEOUT_EN, TIMEOUT=4, no ack -> mem_req drops after 4 cycles, err and done pulse together.

Source files
------------

// File: rtl/ldst_pointer_unit_if.sv
// Data-memory request/acknowledge bus between the LD/ST pointer unit and data memory.
// The unit is the master: it owns request, direction, address and write data;
// memory answers with a single-cycle acknowledge and the load byte.
interface ldst_pointer_unit_if #(
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ack;
    logic [7:0]        mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/ldst_pointer_unit.sv
// LD/ST sequencer for the risc8 core using pointer pairs X/Y/Z (r26/r28/r30).
// Reads the pointer word and store byte, forms the effective address (plain,
// post-increment, pre-decrement, displacement), runs one memory transaction and
// then serializes the pointer word write and the load byte write onto the single
// regfile write port (pointer first, so a load into the pointer register wins).
// Optional feature: define LDST_TIMEOUT_EN to add an ack watchdog with an err pulse.
module ldst_pointer_unit #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [1:0]  mode,
    input  logic [5:0]  q,
    input  logic [5:0]  ptr_reg,
    input  logic [5:0]  data_reg,
    output logic        busy,
    output logic        done,
    output logic [5:0]  rf_a,
    output logic [5:0]  rf_b,
    input  logic [15:0] rf_Ra,
    input  logic [7:0]  rf_Rb,
    output logic        rf_write,
    output logic        rf_write_word,
    output logic [5:0]  rf_d,
    output logic [15:0] rf_Rd,
`ifdef LDST_TIMEOUT_EN
    output logic        err,
`endif
    ldst_pointer_unit_if.master mem
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_REQ,
        S_PTR,
        S_DATA
    } state_t;

    localparam logic [1:0] MODE_PLAIN = 2'b00;
    localparam logic [1:0] MODE_INC   = 2'b01;
    localparam logic [1:0] MODE_DEC   = 2'b10;
    localparam logic [1:0] MODE_DISP  = 2'b11;

    state_t      state_q, state_d;
    logic        is_store_q, is_store_d;
    logic [1:0]  mode_q, mode_d;
    logic [5:0]  q_q, q_d;
    logic [5:0]  ptr_reg_q, ptr_reg_d;
    logic [5:0]  data_reg_q, data_reg_d;
    logic [15:0] eff_q, eff_d;
    logic [15:0] new_ptr_q, new_ptr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        mem_req;
    logic        ptr_update;

`ifdef LDST_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [TW-1:0] cnt_q, cnt_d;
`else
    // The watchdog limit has no meaning without the watchdog.
    if (TIMEOUT < 0) begin : g_timeout_unused
    end
`endif

    // Only post-increment and pre-decrement write the pointer back.
    assign ptr_update = (mode_q == MODE_INC) || (mode_q == MODE_DEC);

    // Memory bus driven from captured state so it stays stable while mem_req is high.
    assign mem.mem_req   = mem_req;
    assign mem.mem_we    = mem_req & is_store_q;
    assign mem.mem_addr  = ADDR_W'(eff_q);
    assign mem.mem_wdata = wdata_q;

    // Next-state, capture and output decode for the LD/ST sequence.
    // NOTE: every output and *_d gets a default before the case so no path leaves a value unassigned, which would infer a latch.
    always_comb begin
        state_d       = state_q;
        is_store_d    = is_store_q;
        mode_d        = mode_q;
        q_d           = q_q;
        ptr_reg_d     = ptr_reg_q;
        data_reg_d    = data_reg_q;
        eff_d         = eff_q;
        new_ptr_d     = new_ptr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        busy          = (state_q != S_IDLE);
        done          = 1'b0;
        rf_a          = 6'd0;
        rf_b          = 6'd0;
        rf_write      = 1'b0;
        rf_write_word = 1'b0;
        rf_d          = 6'd0;
        rf_Rd         = 16'h0000;
        mem_req       = 1'b0;
`ifdef LDST_TIMEOUT_EN
        err           = 1'b0;
        cnt_d         = '0;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_store_d = is_store;
                    mode_d     = mode;
                    q_d        = q;
                    ptr_reg_d  = ptr_reg;
                    data_reg_d = data_reg;
                    // Addresses go out in the accept cycle so the read data
                    // is available by the end of RD.
                    rf_a       = ptr_reg;
                    rf_b       = data_reg;
                    state_d    = S_RD;
                end
            end

            S_RD: begin
                rf_a       = ptr_reg_q;
                rf_b       = data_reg_q;
                wdata_d    = rf_Rb;
                case (mode_q)
                    MODE_DEC:  eff_d = rf_Ra - 16'd1;
                    MODE_DISP: eff_d = rf_Ra + {10'd0, q_q};
                    default:   eff_d = rf_Ra;
                endcase
                case (mode_q)
                    MODE_INC: new_ptr_d = rf_Ra + 16'd1;
                    MODE_DEC: new_ptr_d = rf_Ra - 16'd1;
                    default:  new_ptr_d = rf_Ra;
                endcase
                state_d    = S_REQ;
            end

            S_REQ: begin
                mem_req = 1'b1;
                if (mem.mem_ack) begin
                    rdata_d = mem.mem_rdata;
                    if (ptr_update) begin
                        state_d = S_PTR;
                    end else if (!is_store_q) begin
                        state_d = S_DATA;
                    end else begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
`ifdef LDST_TIMEOUT_EN
                else if (cnt_q == TW'(TIMEOUT - 1)) begin
                    // Give up: no regfile writes for an op whose data never came.
                    done    = 1'b1;
                    err     = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
`endif
            end

            S_PTR: begin
                rf_write      = 1'b1;
                rf_write_word = 1'b1;
                rf_d          = ptr_reg_q;
                rf_Rd         = new_ptr_q;
                if (!is_store_q) begin
                    state_d = S_DATA;
                end else begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end

            S_DATA: begin
                rf_write = 1'b1;
                rf_d     = data_reg_q;
                rf_Rd    = {8'h00, rdata_q};
                done     = 1'b1;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and operand registers; reset mid-op simply returns to IDLE.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            is_store_q <= 1'b0;
            mode_q     <= MODE_PLAIN;
            q_q        <= 6'd0;
            ptr_reg_q  <= 6'd0;
            data_reg_q <= 6'd0;
            eff_q      <= 16'h0000;
            new_ptr_q  <= 16'h0000;
            wdata_q    <= 8'h00;
            rdata_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            mode_q     <= mode_d;
            q_q        <= q_d;
            ptr_reg_q  <= ptr_reg_d;
            data_reg_q <= data_reg_d;
            eff_q      <= eff_d;
            new_ptr_q  <= new_ptr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
        end
    end

`ifdef LDST_TIMEOUT_EN
    // Ack watchdog: counts REQ cycles that pass without mem_ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_ldst_pointer_unit.sv
// Self-checking bench for ldst_pointer_unit: a table of directed LD/ST operations
// with hand-computed addresses, writes and latencies, plus reset-mid-op and
// (when LDST_TIMEOUT_EN is defined) ack-timeout sequences.
module tb_ldst_pointer_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        is_store;
    logic [1:0]  mode;
    logic [5:0]  q;
    logic [5:0]  ptr_reg;
    logic [5:0]  data_reg;
    logic        busy;
    logic        done;
    logic [5:0]  rf_a;
    logic [5:0]  rf_b;
    logic [15:0] rf_Ra;
    logic [7:0]  rf_Rb;
    logic        rf_write;
    logic        rf_write_word;
    logic [5:0]  rf_d;
    logic [15:0] rf_Rd;
`ifdef LDST_TIMEOUT_EN
    logic        err;
`endif

    logic [7:0]  regs [64];
    int          n_checks;
    int          n_fail;

    ldst_pointer_unit_if #(.ADDR_W(16)) mem_if ();

    ldst_pointer_unit #(
        .ADDR_W  (16),
        .TIMEOUT (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .is_store      (is_store),
        .mode          (mode),
        .q             (q),
        .ptr_reg       (ptr_reg),
        .data_reg      (data_reg),
        .busy          (busy),
        .done          (done),
        .rf_a          (rf_a),
        .rf_b          (rf_b),
        .rf_Ra         (rf_Ra),
        .rf_Rb         (rf_Rb),
        .rf_write      (rf_write),
        .rf_write_word (rf_write_word),
        .rf_d          (rf_d),
        .rf_Rd         (rf_Rd),
`ifdef LDST_TIMEOUT_EN
        .err           (err),
`endif
        .mem           (mem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Regfile read ports: data appears one cycle after the address.
    always @(posedge clk) begin
        rf_Ra <= {regs[rf_a | 6'd1], regs[rf_a]};
        rf_Rb <= regs[rf_b];
    end

    typedef struct {
        logic        is_store;
        logic [1:0]  mode;
        logic [5:0]  q;
        logic [5:0]  ptr_reg;
        logic [5:0]  data_reg;
        logic [15:0] ptr_init;
        logic [7:0]  data_init;
        logic [7:0]  rdata;
        int          ack_delay;
        bit          hold_start;
        logic [15:0] exp_addr;
        logic        exp_we;
        logic [7:0]  exp_wdata;
        int          exp_nwr;
        logic        w0_word;
        logic [5:0]  w0_addr;
        logic [15:0] w0_data;
        logic        w1_word;
        logic [5:0]  w1_addr;
        logic [15:0] w1_data;
        int          exp_done;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          cyc;
        int          done_cyc;
        int          nreq;
        int          nwr;
        bit          got_done;
        bit          busy_ok;
        bit          stable;
        logic [15:0] addr0;
        logic        we0;
        logic [7:0]  wd0;
        logic        ww [2];
        logic [5:0]  wa [2];
        logic [15:0] wdv [2];
        string       tag;

        tag      = $sformatf("v%0d", idx);
        done_cyc = 0;
        nreq     = 0;
        nwr      = 0;
        got_done = 1'b0;
        busy_ok  = 1'b1;
        stable   = 1'b1;
        addr0    = 16'h0;
        we0      = 1'b0;
        wd0      = 8'h0;
        for (int i = 0; i < 2; i++) begin
            ww[i]  = 1'b0;
            wa[i]  = 6'd0;
            wdv[i] = 16'h0;
        end

        @(negedge clk);
        regs[v.data_reg]        = v.data_init;
        regs[v.ptr_reg]         = v.ptr_init[7:0];
        regs[v.ptr_reg | 6'd1]  = v.ptr_init[15:8];
        start    = 1'b1;
        is_store = v.is_store;
        mode     = v.mode;
        q        = v.q;
        ptr_reg  = v.ptr_reg;
        data_reg = v.data_reg;
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = ~v.rdata;

        for (cyc = 1; cyc <= 40 && !got_done; cyc++) begin
            if (cyc > 1) begin
                @(negedge clk);
                if (v.hold_start) begin
                    // A second request with different operands while busy.
                    start    = 1'b1;
                    is_store = ~v.is_store;
                    mode     = 2'b11;
                    ptr_reg  = 6'd20;
                    data_reg = 6'd12;
                end else begin
                    start = 1'b0;
                end
            end
            #1;
            if (busy !== (cyc > 1)) busy_ok = 1'b0;
            if (mem_if.mem_req) begin
                nreq++;
                if (nreq == 1) begin
                    addr0 = mem_if.mem_addr;
                    we0   = mem_if.mem_we;
                    wd0   = mem_if.mem_wdata;
                end else if (mem_if.mem_addr !== addr0 || mem_if.mem_wdata !== wd0 ||
                             mem_if.mem_we !== we0) begin
                    stable = 1'b0;
                end
                if (nreq > v.ack_delay) begin
                    mem_if.mem_ack   = 1'b1;
                    mem_if.mem_rdata = v.rdata;
                end else begin
                    mem_if.mem_ack   = 1'b0;
                    mem_if.mem_rdata = ~v.rdata;
                end
            end else begin
                mem_if.mem_ack   = 1'b0;
                mem_if.mem_rdata = ~v.rdata;
            end
            #1;
            if (rf_write) begin
                if (nwr < 2) begin
                    ww[nwr]  = rf_write_word;
                    wa[nwr]  = rf_d;
                    wdv[nwr] = rf_Rd;
                end
                regs[rf_d] = rf_Rd[7:0];
                if (rf_write_word) regs[rf_d | 6'd1] = rf_Rd[15:8];
                nwr++;
            end
            if (done) begin
                got_done = 1'b1;
                done_cyc = cyc;
            end
        end

        @(negedge clk);
        start            = 1'b0;
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = 8'h00;
        #1;

        if (!got_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_done_timeout: no done within 40 cycles", tag);
        end
        check({tag, "_done_cycle"}, done_cyc, v.exp_done);
        check({tag, "_busy_window"}, {31'd0, busy_ok}, 32'd1);
        check({tag, "_mem_addr"}, {16'd0, addr0}, {16'd0, v.exp_addr});
        check({tag, "_mem_we"}, {31'd0, we0}, {31'd0, v.exp_we});
        if (v.is_store) check({tag, "_mem_wdata"}, {24'd0, wd0}, {24'd0, v.exp_wdata});
        check({tag, "_req_stable"}, {31'd0, stable}, 32'd1);
        check({tag, "_n_writes"}, nwr, v.exp_nwr);
        if (v.exp_nwr >= 1) begin
            check({tag, "_w0"}, {9'd0, ww[0], wa[0], wdv[0]}, {9'd0, v.w0_word, v.w0_addr, v.w0_data});
        end
        if (v.exp_nwr >= 2) begin
            check({tag, "_w1"}, {9'd0, ww[1], wa[1], wdv[1]}, {9'd0, v.w1_word, v.w1_addr, v.w1_data});
        end
        if (!v.is_store) check({tag, "_dest_reg"}, {24'd0, regs[v.data_reg]}, {24'd0, v.rdata});
        check({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        bit saw_write;

        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 64; i++) regs[i] = 8'h00;
        reset_n  = 1'b0;
        start    = 1'b0;
        is_store = 1'b0;
        mode     = 2'b00;
        q        = 6'd0;
        ptr_reg  = 6'd0;
        data_reg = 6'd0;
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = 8'h00;

        //        st mode   q   ptr data ptr_init  dinit  rdata  dly hold addr     we wdata  nwr w0w w0a w0d       w1w w1a w1d      done
        vecs[0] = '{1'b0, 2'b00, 6'd0,  6'd26, 6'd5,  16'h0120, 8'h00, 8'hA5, 0, 1'b0, 16'h0120, 1'b0, 8'h00, 1, 1'b0, 6'd5,  16'h00A5, 1'b0, 6'd0,  16'h0000, 4};
        vecs[1] = '{1'b1, 2'b01, 6'd0,  6'd28, 6'd7,  16'hFFFF, 8'h3C, 8'h00, 0, 1'b0, 16'hFFFF, 1'b1, 8'h3C, 1, 1'b1, 6'd28, 16'h0000, 1'b0, 6'd0,  16'h0000, 4};
        vecs[2] = '{1'b0, 2'b10, 6'd0,  6'd30, 6'd0,  16'h0000, 8'h00, 8'h77, 0, 1'b0, 16'hFFFF, 1'b0, 8'h00, 2, 1'b1, 6'd30, 16'hFFFF, 1'b0, 6'd0,  16'h0077, 5};
        vecs[3] = '{1'b0, 2'b11, 6'd63, 6'd30, 6'd1,  16'h1000, 8'h00, 8'h42, 5, 1'b0, 16'h103F, 1'b0, 8'h00, 1, 1'b0, 6'd1,  16'h0042, 1'b0, 6'd0,  16'h0000, 9};
        vecs[4] = '{1'b1, 2'b00, 6'd0,  6'd26, 6'd2,  16'h0456, 8'h99, 8'h00, 2, 1'b1, 16'h0456, 1'b1, 8'h99, 0, 1'b0, 6'd0,  16'h0000, 1'b0, 6'd0,  16'h0000, 5};
        vecs[5] = '{1'b0, 2'b01, 6'd0,  6'd26, 6'd26, 16'h00FF, 8'h00, 8'hC3, 0, 1'b0, 16'h00FF, 1'b0, 8'h00, 2, 1'b1, 6'd26, 16'h0100, 1'b0, 6'd26, 16'h00C3, 5};
        vecs[6] = '{1'b1, 2'b10, 6'd0,  6'd28, 6'd3,  16'h0001, 8'h11, 8'h00, 0, 1'b0, 16'h0000, 1'b1, 8'h11, 1, 1'b1, 6'd28, 16'h0000, 1'b0, 6'd0,  16'h0000, 4};
        vecs[7] = '{1'b1, 2'b11, 6'd5,  6'd30, 6'd4,  16'hFFFE, 8'h80, 8'h00, 1, 1'b0, 16'h0003, 1'b1, 8'h80, 0, 1'b0, 6'd0,  16'h0000, 1'b0, 6'd0,  16'h0000, 4};
        vecs[8] = '{1'b0, 2'b01, 6'd0,  6'd30, 6'd9,  16'hFFFF, 8'h00, 8'h01, 0, 1'b1, 16'hFFFF, 1'b0, 8'h00, 2, 1'b1, 6'd30, 16'h0000, 1'b0, 6'd9,  16'h0001, 5};

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("reset_ctrl", {26'd0, busy, done, rf_write, rf_write_word, mem_if.mem_req, mem_if.mem_we}, 32'd0);
        check("reset_mem_bus", {8'd0, mem_if.mem_addr, mem_if.mem_wdata}, 32'd0);
        check("reset_rf_addr", {14'd0, rf_a, rf_b, rf_d}, 32'd0);
        check("reset_rf_data", {16'd0, rf_Rd}, 32'd0);
`ifdef LDST_TIMEOUT_EN
        check("reset_err", {31'd0, err}, 32'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Reset while waiting for ack: op aborts with no regfile write.
        saw_write = 1'b0;
        @(negedge clk);
        regs[26] = 8'h34;
        regs[27] = 8'h12;
        regs[5]  = 8'hEE;
        start    = 1'b1;
        is_store = 1'b0;
        mode     = 2'b01;
        ptr_reg  = 6'd26;
        data_reg = 6'd5;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (rf_write) saw_write = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        check("abort_in_req", {30'd0, busy, mem_if.mem_req}, 32'd3);
        check("abort_req_addr", {16'd0, mem_if.mem_addr}, 32'h1234);
        reset_n = 1'b0;
        #1;
        check("abort_reset_ctrl", {26'd0, busy, done, rf_write, rf_write_word, mem_if.mem_req, mem_if.mem_we}, 32'd0);
        check("abort_reset_bus", {8'd0, mem_if.mem_addr, mem_if.mem_wdata}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        mem_if.mem_ack = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (rf_write || busy) saw_write = 1'b1;
            @(negedge clk);
        end
        mem_if.mem_ack = 1'b0;
        check("abort_no_write", {31'd0, saw_write}, 32'd0);
        check("abort_regs_kept", {8'd0, regs[27], regs[26], regs[5]}, 32'h1234EE);

`ifdef LDST_TIMEOUT_EN
        // No ack: four REQ cycles, done and err together in the last one.
        begin
            int  nreq;
            bit  got;
            bit  together;
            nreq      = 0;
            got       = 1'b0;
            together  = 1'b0;
            saw_write = 1'b0;
            @(negedge clk);
            start    = 1'b1;
            is_store = 1'b0;
            mode     = 2'b01;
            ptr_reg  = 6'd26;
            data_reg = 6'd5;
            for (int c = 0; c < 20 && !got; c++) begin
                #1;
                if (mem_if.mem_req) nreq++;
                if (rf_write) saw_write = 1'b1;
                if (done) begin
                    got      = 1'b1;
                    together = err;
                end else if (err) begin
                    together = 1'b0;
                end
                @(negedge clk);
                start = 1'b0;
            end
            #1;
            check("timeout_done_seen", {31'd0, got}, 32'd1);
            check("timeout_req_cycles", nreq, 4);
            check("timeout_err_with_done", {31'd0, together}, 32'd1);
            check("timeout_after", {29'd0, mem_if.mem_req, err, busy}, 32'd0);
            check("timeout_no_write", {31'd0, saw_write}, 32'd0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
